// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encoder and the instruction field decoder:
// word widths, the fixed 40-bit field layout, operand types and encoder states.
package instr_pkg;

  // Word and field widths
  localparam int INSTRUCTION_WIDTH = 40;
  localparam int OPCODE_WIDTH      = 6;
  localparam int VALUE_WIDTH       = 8;
  localparam int ADDR_WIDTH        = 8;
  localparam int PROGRAM_DEPTH     = 256;
  localparam int FIELD_WIDTH       = 8;
  localparam int TYPE_WIDTH        = 2;
  localparam int RHA_WIDTH         = 3;

  // Register indices fit in the low bits of an address field; anything above is out of range
  localparam int REG_INDEX_BITS    = 3;

  // Field bit positions within the instruction word
  localparam int RHA1_BIT   = 39;  // operand-1 register-indirect flag
  localparam int RHA2_BIT   = 38;  // operand-2 register-indirect flag
  localparam int OPCODE_MSB = 37;
  localparam int OPCODE_LSB = 32;
  localparam int ADDR1_MSB  = 31;
  localparam int ADDR1_LSB  = 24;
  localparam int ADDR2_MSB  = 23;
  localparam int ADDR2_LSB  = 16;
  localparam int ADDRO_MSB  = 15;
  localparam int ADDRO_LSB  = 8;
  localparam int RSVD_BIT   = 7;   // always zero
  localparam int RHAO_BIT   = 6;   // output register-indirect flag
  localparam int TYPE1_MSB  = 5;
  localparam int TYPE1_LSB  = 4;
  localparam int TYPE2_MSB  = 3;
  localparam int TYPE2_LSB  = 2;
  localparam int TYPEO_MSB  = 1;
  localparam int TYPEO_LSB  = 0;

  // Operand addressing type carried in the 2-bit type fields
  typedef enum logic [1:0] {
    OPND_DIRECT    = 2'd0,
    OPND_REGISTER  = 2'd1,
    OPND_INDIRECT  = 2'd2,
    OPND_IMMEDIATE = 2'd3
  } operand_type_e;

  // Encoder load-session state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } enc_state_e;

  // True when an address field used as a register index points past the register file
  function automatic logic reg_index_bad(input logic [FIELD_WIDTH-1:0] field);
    return (field[FIELD_WIDTH-1:REG_INDEX_BITS] != {(FIELD_WIDTH-REG_INDEX_BITS){1'b0}});
  endfunction

endpackage

// File: rtl/instruction_pack.sv
// Pure combinational field-to-word packer with field consistency check.
// Shared by the encoder and by testbenches that need golden words.
module instruction_pack
  import instr_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0]      opCode,
  input  logic [FIELD_WIDTH-1:0]       address1In,
  input  logic [FIELD_WIDTH-1:0]       address2In,
  input  logic [FIELD_WIDTH-1:0]       addressOut,
  input  logic [TYPE_WIDTH-1:0]        address1Type,
  input  logic [TYPE_WIDTH-1:0]        address2Type,
  input  logic [TYPE_WIDTH-1:0]        outType,
  input  logic [RHA_WIDTH-1:0]         registerHasAddress,
  input  logic                         useValue,
  input  logic [VALUE_WIDTH-1:0]       instructionValue,
  output logic [INSTRUCTION_WIDTH-1:0] instructionWord,
  output logic                         fieldError
);

  logic [INSTRUCTION_WIDTH-1:0] word_s;
  logic [FIELD_WIDTH-1:0]       operand2_s;
  logic                         error_s;

  // Select the second operand: an immediate value replaces address2In
  always_comb begin
    operand2_s = address2In;
    if (useValue) begin
      operand2_s = instructionValue;
    end else begin
      operand2_s = address2In;
    end
  end

  // Place every field at its fixed bit position; reserved bit stays zero
  always_comb begin
    word_s                       = {INSTRUCTION_WIDTH{1'b0}};
    word_s[RHA1_BIT]             = registerHasAddress[2];
    word_s[RHA2_BIT]             = registerHasAddress[1];
    word_s[OPCODE_MSB:OPCODE_LSB] = opCode;
    word_s[ADDR1_MSB:ADDR1_LSB]  = address1In;
    word_s[ADDR2_MSB:ADDR2_LSB]  = operand2_s;
    word_s[ADDRO_MSB:ADDRO_LSB]  = addressOut;
    word_s[RSVD_BIT]             = 1'b0;
    word_s[RHAO_BIT]             = registerHasAddress[0];
    word_s[TYPE1_MSB:TYPE1_LSB]  = address1Type;
    word_s[TYPE2_MSB:TYPE2_LSB]  = address2Type;
    word_s[TYPEO_MSB:TYPEO_LSB]  = outType;
  end

  // Flag register indices out of range, and an immediate paired with register-indirect operand 2
  always_comb begin
    error_s = 1'b0;
    if (registerHasAddress[2] && reg_index_bad(address1In)) begin
      error_s = 1'b1;
    end else if (registerHasAddress[1] && reg_index_bad(address2In)) begin
      error_s = 1'b1;
    end else if (registerHasAddress[0] && reg_index_bad(addressOut)) begin
      error_s = 1'b1;
    end else if (useValue && registerHasAddress[1]) begin
      error_s = 1'b1;
    end else begin
      error_s = 1'b0;
    end
  end

  assign instructionWord = word_s;
  assign fieldError      = error_s;

endmodule

// File: rtl/instruction_encoder.sv
// Builds a program at run time: packs each accepted field beat into an
// instruction word and writes it to consecutive program-memory addresses.
module instruction_encoder
  import instr_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = instr_pkg::INSTRUCTION_WIDTH,
  parameter int OPCODE_WIDTH      = instr_pkg::OPCODE_WIDTH,
  parameter int VALUE_WIDTH       = instr_pkg::VALUE_WIDTH,
  parameter int ADDR_WIDTH        = instr_pkg::ADDR_WIDTH,
  parameter int PROGRAM_DEPTH     = instr_pkg::PROGRAM_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        baseAddress,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic [OPCODE_WIDTH-1:0]      opCode,
  input  logic [7:0]                   address1In,
  input  logic [7:0]                   address2In,
  input  logic [7:0]                   addressOut,
  input  logic [1:0]                   address1Type,
  input  logic [1:0]                   address2Type,
  input  logic [1:0]                   outType,
  input  logic [2:0]                   registerHasAddress,
  input  logic                         useValue,
  input  logic [VALUE_WIDTH-1:0]       instructionValue,
  output logic                         memWrite,
  output logic [ADDR_WIDTH-1:0]        memAddress,
  output logic [INSTRUCTION_WIDTH-1:0] memData,
  output logic [ADDR_WIDTH:0]          count,
  output logic                         full,
  output logic                         fieldError
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(PROGRAM_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  enc_state_e                   state_r;
  enc_state_e                   state_s;
  logic [ADDR_WIDTH-1:0]        base_r;
  logic [CW-1:0]                count_r;
  logic [CW-1:0]                count_inc_s;
  logic                         full_r;
  logic                         field_error_r;
  logic                         mem_write_r;
  logic [ADDR_WIDTH-1:0]        mem_addr_r;
  logic [INSTRUCTION_WIDTH-1:0] mem_data_r;
  logic [INSTRUCTION_WIDTH-1:0] word_s;
  logic                         pack_error_s;
  logic                         in_ready_s;
  logic                         accept_s;
  logic                         last_beat_s;

  instruction_pack u_pack (
    .opCode             (opCode),
    .address1In         (address1In),
    .address2In         (address2In),
    .addressOut         (addressOut),
    .address1Type       (address1Type),
    .address2Type       (address2Type),
    .outType            (outType),
    .registerHasAddress (registerHasAddress),
    .useValue           (useValue),
    .instructionValue   (instructionValue),
    .instructionWord    (word_s),
    .fieldError         (pack_error_s)
  );

  // Handshake: accept only while loading, not restarting and not yet full
  always_comb begin
    in_ready_s = 1'b0;
    if ((state_r == LOAD) && !start && !full_r) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    accept_s    = inValid & in_ready_s;
    count_inc_s = count_r + ONE_C;
    last_beat_s = (count_inc_s == DEPTH_C);
  end

  // Session state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: start always (re)opens a session; the filling beat closes it
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (start) begin
          state_s = LOAD;
        end else if (accept_s && last_beat_s) begin
          state_s = FULL;
        end else begin
          state_s = LOAD;
        end
      end
      FULL: begin
        if (start) begin
          state_s = LOAD;
        end else begin
          state_s = FULL;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output write port: one-cycle registered write of each accepted word at base + count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_write_r <= 1'b0;
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_data_r  <= {INSTRUCTION_WIDTH{1'b0}};
    end else begin
      mem_write_r <= accept_s;
      if (accept_s) begin
        mem_addr_r <= base_r + count_r[ADDR_WIDTH-1:0];
        mem_data_r <= word_s;
      end
    end
  end

  // Session bookkeeping: base, word count, full flag and sticky field error
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_r        <= {ADDR_WIDTH{1'b0}};
      count_r       <= {CW{1'b0}};
      full_r        <= 1'b0;
      field_error_r <= 1'b0;
    end else if (start) begin
      base_r        <= baseAddress;
      count_r       <= {CW{1'b0}};
      full_r        <= 1'b0;
      field_error_r <= 1'b0;
    end else if (accept_s) begin
      count_r       <= count_inc_s;
      full_r        <= last_beat_s;
      field_error_r <= field_error_r | pack_error_s;
    end
  end

  assign inReady    = in_ready_s;
  assign memWrite   = mem_write_r;
  assign memAddress = mem_addr_r;
  assign memData    = mem_data_r;
  assign count      = count_r;
  assign full       = full_r;
  assign fieldError = field_error_r;

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Packs decoded instruction fields back into a single INSTRUCTION_WIDTH-bit instruction word and writes consecutive words into program memory. It is the inverse of the instruction field decoder, and its bit layout must round-trip through that decoder exactly. It sits between the program loader or test host and the program-memory write port, and is used to build programs from fields at run time.

## Interface
- INSTRUCTION_WIDTH, 40: instruction word width; the layout below is fixed for 40.
- OPCODE_WIDTH, 6: opcode field width.
- VALUE_WIDTH, 8: immediate value width.
- ADDR_WIDTH, 8: program-memory address width.
- PROGRAM_DEPTH, 256: maximum number of words per load session (≤ 2^ADDR_WIDTH).

Ports:
- clock  in  1  — single clock, rising edge.
- reset  in  1  — asynchronous, active-high.
- start  in  1  — begin a load session at baseAddress.
- baseAddress  in  ADDR_WIDTH  — first write address, sampled when start is high.
- inValid  in  1 / inReady  out  1  — field-beat handshake.
- opCode  in  OPCODE_WIDTH
- address1In, address2In, addressOut  in  8 each
- address1Type, address2Type, outType  in  2 each
- registerHasAddress  in  3  — {op1, op2, out} register-indirect flags.
- useValue  in  1  — when set, instructionValue replaces address2In.
- instructionValue  in  VALUE_WIDTH
- memWrite  out  1, memAddress  out  ADDR_WIDTH, memData  out  INSTRUCTION_WIDTH
- count  out  ADDR_WIDTH+1  — words accepted this session.
- full  out  1  — count == PROGRAM_DEPTH.
- fieldError  out  1  — sticky per session.

## Operation
- Word layout (bit 39 = MSB):
  - [39] = registerHasAddress[2]; [38] = registerHasAddress[1]
  - [37:32] = opCode; [31:24] = address1In
  - [23:16] = useValue ? instructionValue : address2In
  - [15:8] = addressOut; [7] = 0 (reserved); [6] = registerHasAddress[0]
  - [5:4] = address1Type; [3:2] = address2Type; [1:0] = outType
- FSM states:
  - IDLE → LOAD on start.
  - LOAD → FULL when an accepted beat makes count == PROGRAM_DEPTH.
  - FULL → LOAD on start.
  - LOAD → LOAD on start (restart).
- Handshake:
  - inReady = (state == LOAD) & ~start & ~full.
  - A beat is accepted when inValid & inReady.
- Address and count:
  - memAddress = baseAddress + count (mod 2^ADDR_WIDTH), so the address wraps past the top of memory.
  - start clears count and fieldError and latches baseAddress.
- fieldError is set on an accepted beat if either condition holds:
  - registerHasAddress[i] is set and the matching address field bits [7:3] are nonzero (register index out of range).
  - useValue is set and registerHasAddress[1] is set.
  - The word is still written.

## Timing
- Reset values: state = IDLE, inReady = 0, memWrite = 0, memAddress = 0, memData = 0, count = 0, full = 0, fieldError = 0.
- Latency is one cycle. A beat accepted in cycle N produces memWrite = 1 in cycle N+1, with registered memData and memAddress. count increments in cycle N+1.
- Back-to-back beats are supported at one word per cycle with no bubbles.
- start and inValid in the same cycle: start wins and the beat is not accepted.
- A write registered before a start still completes in the next cycle at its old address.
- When the beat that fills the session is accepted, full and inReady = 0 take effect the next cycle. That beat's write still occurs.
- Asserting reset mid-session aborts it immediately. Any pending write is dropped.

## Structure
- Shared package instr_pkg holds:
  - the width constants;
  - field bit-position localparams (OPCODE_MSB, ADDR1_MSB, ...);
  - the operand-type enum (2-bit);
  - the encoder state enum {IDLE, LOAD, FULL}.
- The decoder reads its field positions from this same package.
- One combinational sub-module, instruction_pack, does the pure field→word packing and error check. It is reusable by testbenches. The encoder wraps it with the FSM, counter and output register.

## Test plan
- Reset, then start with baseAddress = 0x10. Send opCode = 0x2A, address1In = 0x03, address2In = 0x44, addressOut = 0x05, types 1/2/3, registerHasAddress = 3'b101, useValue = 0. Expect memWrite one cycle later at 0x10 with memData = 0xAA_03_44_05_5B. Feeding that word to the decoder returns the identical fields.
- useValue = 1, instructionValue = 0x7F, address2In = 0x11. Expect memData[23:16] = 0x7F and fieldError = 0.
- Set PROGRAM_DEPTH = 4 and stream 6 back-to-back beats. Expect 4 writes to consecutive addresses, full = 1, and inReady = 0 from the cycle after the 4th acceptance. Beats 5 and 6 stall.
- baseAddress = 0xFE, 3 beats. Expect writes at 0xFE, 0xFF, 0x00.
- registerHasAddress[2] = 1 with address1In = 0x09. Expect fieldError = 1 and the word still written. A following start clears fieldError.
- start and inValid asserted together while a beat is pending, then reset asserted mid-stream. Expect the beat not accepted, and all outputs at reset values in the same cycle as reset.
